// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - W-bit add/sub sequenced one nibble per clock through an external 4-bit stage
// Optional out_ovf (two's-complement overflow) enabled by macro SIGNED_OVERFLOW_FLAG_EN.
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_sub,
    input  logic                   in_cin,
    output logic [3:0]             nib_a,
    output logic [3:0]             nib_b,
    output logic                   nib_cin,
    output logic                   nib_control,
    input  logic [3:0]             nib_result,
    input  logic                   nib_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_result,
    output logic                   out_cout,
    output logic                   out_zero
`ifdef SIGNED_OVERFLOW_FLAG_EN
   ,output logic                   out_ovf
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_sub;
    logic          r_carry;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_out_result;
    logic          r_out_cout;
    logic          r_out_zero;
`ifdef SIGNED_OVERFLOW_FLAG_EN
    logic          r_out_ovf;
    logic          w_ovf;
`endif

    logic          w_run;
    logic          w_last;
    logic [3:0]    w_nib_a;
    logic [3:0]    w_nib_b;
    logic [W-1:0]  w_res_next;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_idx == IW'(NIBBLES - 1));

    // Select the current nibble and merge the returning one into the partial result.
    always_comb begin
        w_nib_a    = 4'h0;
        w_nib_b    = 4'h0;
        w_res_next = r_res;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IW'(n)) begin
                w_nib_a               = r_a[4*n +: 4];
                w_nib_b               = r_b[4*n +: 4];
                w_res_next[4*n +: 4]  = nib_result;
            end
        end
    end

`ifdef SIGNED_OVERFLOW_FLAG_EN
    assign w_ovf = r_sub ? ((r_a[W-1] != r_b[W-1]) && (w_res_next[W-1] != r_a[W-1]))
                         : ((r_a[W-1] == r_b[W-1]) && (w_res_next[W-1] != r_a[W-1]));
    assign out_ovf = r_out_ovf;
`endif

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign nib_a       = w_run ? w_nib_a : 4'h0;
    assign nib_b       = w_run ? w_nib_b : 4'h0;
    assign nib_cin     = w_run ? r_carry : 1'b0;
    assign nib_control = w_run ? r_sub   : 1'b0;
    assign out_result  = r_out_result;
    assign out_cout    = r_out_cout;
    assign out_zero    = r_out_zero;

    // Output registers load only on the final nibble so they hold through IDLE and RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_sub        <= 1'b0;
            r_carry      <= 1'b0;
            r_idx        <= '0;
            r_res        <= '0;
            r_out_result <= '0;
            r_out_cout   <= 1'b0;
            r_out_zero   <= 1'b1;
`ifdef SIGNED_OVERFLOW_FLAG_EN
            r_out_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_sub   <= in_sub;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                        r_res   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= nib_cout;
                    if (w_last) begin
                        r_idx        <= '0;
                        r_state      <= S_DONE;
                        r_out_result <= w_res_next;
                        r_out_cout   <= nib_cout;
                        r_out_zero   <= (w_res_next == '0);
`ifdef SIGNED_OVERFLOW_FLAG_EN
                        r_out_ovf    <= w_ovf;
`endif
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb/tb_nibble_serial_addsub.sv - randomized and directed checks of nibble_serial_addsub against an arithmetic model
module tb_nibble_serial_addsub;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_sub;
    logic          in_cin;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic          nib_cin;
    logic          nib_control;
    logic [3:0]    stage_res;
    logic          stage_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic          out_cout;
    logic          out_zero;
`ifdef SIGNED_OVERFLOW_FLAG_EN
    logic          out_ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub #(.NIBBLES(NIB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_sub(in_sub),
        .in_cin(in_cin),
        .nib_a(nib_a),
        .nib_b(nib_b),
        .nib_cin(nib_cin),
        .nib_control(nib_control),
        .nib_result(stage_res),
        .nib_cout(stage_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_cout(out_cout),
        .out_zero(out_zero)
`ifdef SIGNED_OVERFLOW_FLAG_EN
       ,.out_ovf(out_ovf)
`endif
    );

    // External 4-bit adder/subtractor stage
    always_comb begin
        int s;
        s = 0;
        if (!nib_control) s = int'(nib_a) + int'(nib_b) + int'(nib_cin);
        else              s = int'(nib_a) - int'(nib_b) - int'(nib_cin);
        stage_res  = s[3:0];
        stage_cout = nib_control ? (s < 0) : (s > 15);
    end

    // Returns {ovf, cout, result} of the whole W-bit operation.
    function automatic logic [W+1:0] ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sub, input logic cin);
        longint s;
        logic [W-1:0] r;
        logic co;
        logic ov;
        if (!sub) begin
            s  = longint'(a) + longint'(b) + longint'(cin);
            co = (s >= (longint'(1) << W));
        end else begin
            s  = longint'(a) - longint'(b) - longint'(cin);
            co = (s < 0);
        end
        r  = s[W-1:0];
        ov = sub ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1]))
                 : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
        return {ov, co, r};
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin,
                         output logic [W-1:0] res, output logic co, output logic zr, output logic ov,
                         output int lat, output logic [31:0] tr);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        tr  = '0;
        while (!out_valid && lat < 30) begin
            tr[lat] = nib_cin;
            @(negedge clk);
            lat++;
        end
        res = out_result;
        co  = out_cout;
        zr  = out_zero;
`ifdef SIGNED_OVERFLOW_FLAG_EN
        ov  = out_ovf;
`else
        ov  = 1'b0;
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_cout !== 1'b0 || out_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b res=%h co=%b z=%b, required 1 0 0000 0 1",
                     in_ready, out_valid, out_result, out_cout, out_zero);
        end
        n_tests++;
        if (nib_a !== 4'h0 || nib_b !== 4'h0 || nib_cin !== 1'b0 || nib_control !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_nib: a=%h b=%h cin=%b ctl=%b, required all 0", nib_a, nib_b, nib_cin, nib_control);
        end
`ifdef SIGNED_OVERFLOW_FLAG_EN
        n_tests++;
        if (out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b required 0", out_ovf);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: rdy=%b vld=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h1000, 16'h0004, 16'h0008};
        logic [W-1:0] tb[6] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0001, 16'h0009, 16'h0001};
        logic         ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic         tc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] er[6] = '{16'h2233, 16'h0000, 16'h8000, 16'h0FFF, 16'hFFFB, 16'h0006};
        logic         ec[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic         ez[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic         eo[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] res;
        logic co, zr, ov;
        int lat;
        logic [31:0] tr;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], ts[i], tc[i], res, co, zr, ov, lat, tr);
            n_tests++;
            if (res !== er[i] || co !== ec[i] || zr !== ez[i]) begin
                n_fail++;
                $display("FAIL directed[%0d]: res/cout/zero %h/%b/%b, required %h/%b/%b",
                         i, res, co, zr, er[i], ec[i], ez[i]);
            end
            n_tests++;
            if (lat !== NIB) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: %0d cycles, required %0d", i, lat, NIB);
            end
`ifdef SIGNED_OVERFLOW_FLAG_EN
            n_tests++;
            if (ov !== eo[i]) begin
                n_fail++;
                $display("FAIL directed_ovf[%0d]: got %b required %b", i, ov, eo[i]);
            end
`else
            if (eo[i] === 1'bx) $display("unexpected table value");
`endif
            if (i == 3) begin
                n_tests++;
                if (tr[3:0] !== 4'b1110) begin
                    n_fail++;
                    $display("FAIL nib_cin_sequence: got %b (lsb first) required 1110", tr[3:0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, res;
        logic sub, cin, co, zr, ov;
        logic [W+1:0] exp;
        int lat;
        logic [31:0] tr;
        for (int i = 0; i < 40; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            if (i % 8 == 1) b = ~a;
            if (i % 8 == 2) b = a;
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
            exp = ref_calc(a, b, sub, cin);
            do_op(a, b, sub, cin, res, co, zr, ov, lat, tr);
            n_tests++;
            if (res !== exp[W-1:0] || co !== exp[W] || zr !== (exp[W-1:0] == '0) || lat !== NIB) begin
                n_fail++;
                $display("FAIL random[%0d] %h %s %h cin=%b: res/cout/zero/lat %h/%b/%b/%0d, required %h/%b/%b/%0d",
                         i, a, sub ? "-" : "+", b, cin, res, co, zr, lat,
                         exp[W-1:0], exp[W], (exp[W-1:0] == '0), NIB);
            end
`ifdef SIGNED_OVERFLOW_FLAG_EN
            n_tests++;
            if (ov !== exp[W+1]) begin
                n_fail++;
                $display("FAIL random_ovf[%0d]: got %b required %b", i, ov, exp[W+1]);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        int guard;
        @(negedge clk);
        in_a = 16'h1234; in_b = 16'h0FFF; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL bp_done_timeout: out_valid=%b required 1", out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || out_result !== 16'h2233 || out_cout !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: vld=%b res=%h co=%b rdy=%b, required 1 2233 0 0",
                         k, out_valid, out_result, out_cout, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 16'h2233) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b res=%h, required 0 1 2233", out_valid, in_ready, out_result);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] res;
        logic co, zr, ov;
        int lat;
        logic [31:0] tr;
        @(negedge clk);
        in_a = 16'hABCD; in_b = 16'h1111; in_sub = 1'b0; in_cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || nib_a !== 4'h0 || nib_b !== 4'h0 ||
            nib_cin !== 1'b0 || nib_control !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset: rdy=%b vld=%b nib a/b/cin/ctl=%h/%h/%b/%b, required 1 0 0/0/0/0",
                     in_ready, out_valid, nib_a, nib_b, nib_cin, nib_control);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, res, co, zr, ov, lat, tr);
        n_tests++;
        if (res !== 16'h0002 || co !== 1'b0 || zr !== 1'b0 || lat !== NIB) begin
            n_fail++;
            $display("FAIL after_reset_add: res/cout/zero/lat %h/%b/%b/%0d, required 0002/0/0/%0d",
                     res, co, zr, lat, NIB);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle W-bit add/subtract sequencer that sits directly upstream of the 4-bit adder/subtractor stage.
- Slices wide operands into nibbles and feeds one nibble per clock to the external 4-bit stage.
- Chains carry/borrow across cycles and collects the result nibbles into a registered W-bit result.
- Valid/ready handshakes on both the operand side and the result side.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (must be at least 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operand request
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_sub  input  1  0 = add, 1 = subtract
- in_cin  input  1  initial carry-in (add) or borrow-in (subtract)
- nib_a  output  4  A nibble to 4-bit stage
- nib_b  output  4  B nibble to 4-bit stage
- nib_cin  output  1  carry/borrow to 4-bit stage
- nib_control  output  1  add/sub select to 4-bit stage
- nib_result  input  4  4-bit stage sum/difference
- nib_cout  input  1  4-bit stage carry-out/borrow-out
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  W  final result
- out_cout  output  1  final carry-out (add) or borrow-out (subtract)
- out_zero  output  1  out_result == 0

Behaviour:
- 4-bit stage contract, combinational:
  - control=0: {cout,result} = a + b + cin.
  - control=1: result = a - b - cin mod 16; cout=1 iff a < b + cin (borrow).
  - The block forwards nib_cout unchanged as next nib_cin; no inversion.
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- Reset values: in_ready=1, out_valid=0, out_result=0, out_cout=0, out_zero=1, nib_* = 0, nibble index=0.
- IDLE:
  - in_ready=1; nib_* driven 0.
  - On in_valid && in_ready at an edge: latch in_a, in_b, in_sub; carry_reg <= in_cin; idx <= 0; go to RUN.
- RUN:
  - in_ready=0.
  - nib_a = a_reg[4*idx+:4], nib_b = b_reg[4*idx+:4], nib_cin = carry_reg, nib_control = sub_reg (all combinational from registers).
  - Each edge: res_reg[4*idx+:4] <= nib_result; carry_reg <= nib_cout; idx <= idx+1.
  - On the edge where idx == NIBBLES-1: go to DONE.
- DONE:
  - out_valid=1; out_result=res_reg, out_cout=carry_reg, out_zero=(res_reg==0).
  - Outputs held stable while out_ready=0.
  - On out_valid && out_ready at an edge: go to IDLE. in_ready=1 from the following cycle; no back-to-back acceptance in DONE.
- Latency: out_valid rises exactly NIBBLES cycles after the input handshake edge. Throughput: one operation per NIBBLES+2 cycles at most.
- in_a, in_b, in_sub and in_cin are ignored outside IDLE. A changing in_valid during RUN/DONE has no effect.
- out_result/out_cout keep their last values in IDLE and RUN; only out_valid qualifies them.
- rst_n low at any time, including mid-RUN: immediate return to reset values, partial result discarded.
- NIBBLES=1: RUN lasts one cycle.

Optional Feature:
- Macro SIGNED_OVERFLOW_FLAG_EN.
- When defined: adds output out_ovf (1 bit), the two's-complement overflow of the W-bit operation, valid with out_valid, reset 0.
  - Add: sign(a)==sign(b) and sign(result)!=sign(a).
  - Subtract: sign(a)!=sign(b) and sign(result)!=sign(a).
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- NIBBLES=4, add 0x1234+0x0FFF, cin=0 -> out_result=0x2233, out_cout=0, out_zero=0; out_valid rises exactly 4 cycles after accept.
- Add 0xFFFF+0x0001, cin=0 -> out_result=0x0000, out_cout=1, out_zero=1; with SIGNED_OVERFLOW_FLAG_EN, out_ovf=0. Add 0x7FFF+0x0001 -> 0x8000, out_ovf=1.
- Sub 0x1000-0x0001, cin=0 -> nib_cin sequence 0,1,1,1; out_result=0x0FFF, out_cout=0. Sub 0x0004-0x0009 -> 0xFFFB, out_cout=1.
- Sub 0x0008-0x0001 with in_cin=1 (borrow-in) -> out_result=0x0006, out_cout=0.
- out_ready held 0 for 3 cycles in DONE -> out_valid, out_result and out_cout stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- rst_n pulsed low after 2 RUN cycles -> immediately in_ready=1, out_valid=0, nib_*=0; a subsequent add 0x0001+0x0001 completes with 0x0002.
